// File: rtl/mul_share_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
// Used by mul_share_arb and its sub-blocks.
package mul_share_pkg;

    localparam int MUL_W       = 6;
    localparam int MUL_NUM_REQ = 4;
    localparam int STAT_W      = 16;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/basic_mul_top.sv
// Plain combinational unsigned multiplier with a full-width product.
// Shared by all requesters through mul_share_arb.
module basic_mul_top #(
    parameter int width = 6
) (
    input  logic [width-1:0]   x_i,
    input  logic [width-1:0]   y_i,
    output logic [2*width-1:0] p_o
);

    assign p_o = (2*width)'(x_i) * (2*width)'(y_i);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps.
// The one-hot grant is gated by en_i; any_o/idx_o reflect the winner.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        idx_o = '0;
        any_o = 1'b0;
        gnt_o = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                idx_o = ID_W'(j);
            end
        end
        if (en_i && any_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/mul_share_arb.sv
// One multiplier shared round-robin by NUM_REQ requesters, 2-stage pipe.
// Optional per-requester grant counters: define MUL_SHARE_ARB_STATS_EN.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int width   = MUL_W,
    parameter int NUM_REQ = MUL_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*width-1:0] req_x,
    input  logic [NUM_REQ*width-1:0] req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [clog2_min1(NUM_REQ)-1:0] rsp_id,
    output logic [2*width-1:0]       rsp_data
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int ID_W = clog2_min1(NUM_REQ);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s1_valid_q, s2_valid_q;
    logic [width-1:0]   s1_x_q, s1_y_q;
    logic [ID_W-1:0]    s1_id_q, s2_id_q;
    logic [2*width-1:0] s2_p_q, prod;

    logic               s1_take, s2_take, arb_en, xfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gidx;
    logic               gany;
    logic [width-1:0]   x_sel, y_sel;

    assign s2_take = !s2_valid_q || rsp_ready;
    assign s1_take = !s1_valid_q || s2_take;
    // No grants while reset is held, so req_ready reads 0 in reset.
    assign arb_en  = s1_take && !rst;
    assign xfer    = arb_en && gany;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign req_ready = gnt;
    assign x_sel = req_x[int'(gidx)*width +: width];
    assign y_sel = req_y[int'(gidx)*width +: width];

    always_comb begin
        ptr_d = ptr_q;
        if (xfer)
            ptr_d = (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end

    basic_mul_top #(.width(width)) u_mul (
        .x_i (s1_x_q),
        .y_i (s1_y_q),
        .p_o (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (s2_take) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_p_q  <= prod;
                    s2_id_q <= s1_id_q;
                end
            end
            if (s1_take) begin
                s1_valid_q <= xfer;
                if (xfer) begin
                    s1_x_q  <= x_sel;
                    s1_y_q  <= y_sel;
                    s1_id_q <= gidx;
                end
            end
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_p_q;

`ifdef MUL_SHARE_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [STAT_W-1:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else if (gnt[i] && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
        assign grant_cnt[i*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb.
// Stats checks run only when MUL_SHARE_ARB_STATS_EN is defined.
module tb_mul_share_arb;

    localparam int W = 6;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_x, req_y;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [2*W-1:0] rsp_data;
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mul_share_arb #(.width(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef MUL_SHARE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setxy(input int i, input int x, input int y);
        req_x[i*W +: W] = W'(x);
        req_y[i*W +: W] = W'(y);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_id",    64'(rsp_id),    64'(0));
        chk("rst_data",  64'(rsp_data),  64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        rst       = 1'b0;
        tick();

        // single request from requester 2
        setxy(2, 63, 63);
        req_valid = 4'b0100;
        #1;
        chk("single_gnt", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0;
        chk("single_lat", 64'(rsp_valid), 64'(0));
        tick();
        chk("single_v",  64'(rsp_valid), 64'(1));
        chk("single_id", 64'(rsp_id),    64'(2));
        chk("single_d",  64'(rsp_data),  64'(3969));
        tick();
        chk("single_drain", 64'(rsp_valid), 64'(0));

        // pointer is now 3; only requester 0 asks -> wrap
        setxy(0, 0, 45);
        req_valid = 4'b0001;
        #1;
        chk("wrap_gnt", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = 4'b1111;
        #1;
        chk("wrap_ptr1", 64'(req_ready), 64'(4'b0010));
        req_valid = '0;
        tick();
        chk("wrap_v",  64'(rsp_valid), 64'(1));
        chk("wrap_id", 64'(rsp_id),    64'(0));
        chk("wrap_d",  64'(rsp_data),  64'(0));
        tick();

        // reset mid-flight: two transfers then async reset
        setxy(1, 5, 5);
        setxy(2, 7, 7);
        req_valid = 4'b0110;
        tick();
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_v",   64'(rsp_valid), 64'(0));
        chk("mrst_id",  64'(rsp_id),    64'(0));
        chk("mrst_d",   64'(rsp_data),  64'(0));
        chk("mrst_rdy", 64'(req_ready), 64'(0));
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_stale", 64'(rsp_valid), 64'(0));
        end

        // round robin from pointer 0
        for (int i = 0; i < N; i++) setxy(i, i + 1, 2);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 5)
                chk("rr_gnt", 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            if (k >= 1) begin
                chk("rr_v",  64'(rsp_valid), 64'(1));
                chk("rr_id", 64'(rsp_id),    64'((k - 1) % 4));
                chk("rr_d",  64'(rsp_data),  64'(2 * ((k - 1) % 4 + 1)));
            end
        end
        tick();
        chk("rr_drain", 64'(rsp_valid), 64'(0));

        // backpressure with requester 1 streaming
        req_valid = 4'b0010;
        setxy(1, 10, 3);
        tick();
        setxy(1, 11, 3);
        tick();
        setxy(1, 12, 3);
        rsp_ready = 1'b0;
        #1;
        chk("bp_full", 64'(req_ready), 64'(0));
        chk("bp_d0",   64'(rsp_data),  64'(30));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_v",  64'(rsp_valid), 64'(1));
            chk("bp_hold_id", 64'(rsp_id),    64'(1));
            chk("bp_hold_d",  64'(rsp_data),  64'(30));
            chk("bp_hold_r",  64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_gnt", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        chk("bp_r1", 64'(rsp_data), 64'(33));
        tick();
        chk("bp_r2", 64'(rsp_data), 64'(36));
        chk("bp_r2v", 64'(rsp_valid), 64'(1));
        tick();
        chk("bp_end", 64'(rsp_valid), 64'(0));

`ifdef MUL_SHARE_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setxy(0, 1, 1);
        req_valid = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        req_valid = '0;
        chk("cnt0", 64'(grant_cnt[15:0]),  64'(16'hFFFF));
        chk("cnt_other", 64'(grant_cnt[63:16]), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
